// File: rtl/drm_activator_pkg.sv
// Shared field positions and helpers for the DRM activator hub.
// The command and response words use fixed bit positions on the 32-bit stream.
package drm_activator_pkg;

    localparam int NUM_CH_MAX   = 16;
    localparam int CH_FIELD_W   = 4;

    localparam int CMD_DAT      = 0;
    localparam int CMD_WE       = 1;
    localparam int CMD_ADR_LSB  = 2;
    localparam int CMD_CYC      = 4;
    localparam int CMD_CS       = 5;
    localparam int CMD_CH_LSB   = 8;

    localparam int RSP_DAT      = 0;
    localparam int RSP_STA      = 1;
    localparam int RSP_INTR_ANY = 2;
    localparam int RSP_ACK      = 3;
    localparam int RSP_SEL_LSB  = 8;
    localparam int RSP_INTR_LSB = 16;

    typedef struct packed {
        logic [CH_FIELD_W-1:0] ch;
        logic                  cs;
        logic                  cyc;
        logic [1:0]            adr;
        logic                  we;
        logic                  dat;
    } cmd_t;

    function automatic logic [31:0] pack_rsp(input logic dat, input logic sta,
                                             input logic intr_any, input logic ack,
                                             input logic [CH_FIELD_W-1:0] sel,
                                             input logic [15:0] intr);
        logic [31:0] w;
        w = '0;
        w[RSP_DAT]                      = dat;
        w[RSP_STA]                      = sta;
        w[RSP_INTR_ANY]                 = intr_any;
        w[RSP_ACK]                      = ack;
        w[RSP_SEL_LSB +: CH_FIELD_W]    = sel;
        w[RSP_INTR_LSB +: 16]           = intr;
        return w;
    endfunction

endpackage

// File: rtl/drm_activator_axi4st_hub_fifo.sv
// Synchronous response FIFO with combinational head read.
// A write is accepted when full only if a read happens in the same cycle.
module drm_rsp_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     free_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_wr;
    logic          do_rd;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign free_cnt = (AW+1)'(DEPTH) - count_reg;
    assign do_rd    = rd_en && !empty;
    assign do_wr    = wr_en && (!full || do_rd);
    assign rd_data  = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

endmodule

// File: rtl/drm_activator_axi4st_hub.sv
// Routes DRM controller command beats to one of NUM_CH activator slaves and
// streams coalesced slave-response snapshots back through a response FIFO.
module drm_activator_axi4st_hub
    import drm_activator_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int RSP_DEPTH = 8
) (
    input  logic                  drm_aclk,
    input  logic                  drm_arst,
    input  logic [31:0]           drm_to_uip_tdata,
    input  logic                  drm_to_uip_tvalid,
    output logic                  drm_to_uip_tready,
    output logic [31:0]           uip_to_drm_tdata,
    output logic                  uip_to_drm_tvalid,
    input  logic                  uip_to_drm_tready,
    output logic [NUM_CH-1:0]     act_cs,
    output logic [NUM_CH-1:0]     act_cyc,
    output logic [NUM_CH-1:0]     act_we,
    output logic [NUM_CH-1:0]     act_dat,
    output logic [2*NUM_CH-1:0]   act_adr,
    input  logic [NUM_CH-1:0]     act_ack,
    input  logic [NUM_CH-1:0]     act_sta,
    input  logic [NUM_CH-1:0]     act_intr,
    input  logic [NUM_CH-1:0]     act_rdat,
    output logic                  err_bad_ch,
    output logic [7:0]            bad_ch_count
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FREE_W = $clog2(RSP_DEPTH) + 1;

    cmd_t              cmd;
    logic              unused_cmd_bits;
    logic              ch_ok;
    logic              accept;
    logic              load;
    logic [CH_W-1:0]   sel_reg;
    logic              err_reg;
    logic [7:0]        cnt_reg;

    logic [31:0]       rsp_word;
    logic [31:0]       rsp_q_reg;
    logic [31:0]       last_reg;
    logic              force1_reg;
    logic              force2_reg;
    logic              pending_reg;
    logic              changed;
    logic              want;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FREE_W-1:0] free_cnt;

    assign cmd.dat = drm_to_uip_tdata[CMD_DAT];
    assign cmd.we  = drm_to_uip_tdata[CMD_WE];
    assign cmd.adr = drm_to_uip_tdata[CMD_ADR_LSB +: 2];
    assign cmd.cyc = drm_to_uip_tdata[CMD_CYC];
    assign cmd.cs  = drm_to_uip_tdata[CMD_CS];
    assign cmd.ch  = drm_to_uip_tdata[CMD_CH_LSB +: CH_FIELD_W];
    assign unused_cmd_bits = ^{drm_to_uip_tdata[31:12], drm_to_uip_tdata[7:6]};

    assign drm_to_uip_tready = !drm_arst && (free_cnt >= FREE_W'(2));
    assign accept = drm_to_uip_tvalid && drm_to_uip_tready;
    assign ch_ok  = ({1'b0, cmd.ch} < 5'(NUM_CH));
    assign load   = accept && ch_ok;

    // A new command deselects every other channel but leaves their we/adr/dat alone.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic       cs_reg;
        logic       cyc_reg;
        logic       we_reg;
        logic       dat_reg;
        logic [1:0] adr_reg;

        always_ff @(posedge drm_aclk) begin
            if (drm_arst) begin
                cs_reg  <= 1'b0;
                cyc_reg <= 1'b0;
                we_reg  <= 1'b0;
                dat_reg <= 1'b0;
                adr_reg <= 2'b00;
            end else if (load) begin
                if (cmd.ch == CH_FIELD_W'(gi)) begin
                    cs_reg  <= cmd.cs;
                    cyc_reg <= cmd.cyc;
                    we_reg  <= cmd.we;
                    dat_reg <= cmd.dat;
                    adr_reg <= cmd.adr;
                end else begin
                    cs_reg  <= 1'b0;
                    cyc_reg <= 1'b0;
                end
            end
        end

        assign act_cs[gi]          = cs_reg;
        assign act_cyc[gi]         = cyc_reg;
        assign act_we[gi]          = we_reg;
        assign act_dat[gi]         = dat_reg;
        assign act_adr[2*gi +: 2]  = adr_reg;
    end

    always_ff @(posedge drm_aclk) begin
        if (drm_arst) begin
            sel_reg <= '0;
            err_reg <= 1'b0;
            cnt_reg <= 8'd0;
        end else begin
            if (load) sel_reg <= cmd.ch[CH_W-1:0];
            if (accept && !ch_ok) begin
                err_reg <= 1'b1;
                if (cnt_reg != 8'hFF) cnt_reg <= cnt_reg + 8'd1;
            end
        end
    end

    assign err_bad_ch   = err_reg;
    assign bad_ch_count = cnt_reg;

    assign rsp_word = pack_rsp(act_rdat[sel_reg], act_sta[sel_reg], |act_intr, act_ack[sel_reg],
                               CH_FIELD_W'(sel_reg), 16'(act_intr));

    // Change pushes are held off while a forced snapshot is in flight so that a
    // command and a coincident slave change leave the hub as a single beat.
    // Reset primes the force pipeline, which makes the first push unconditional.
    assign pop     = uip_to_drm_tvalid && uip_to_drm_tready;
    assign changed = (rsp_q_reg != last_reg) && !force1_reg;
    assign want    = force2_reg || pending_reg || changed;
    assign push    = want && (!fifo_full || pop);

    always_ff @(posedge drm_aclk) begin
        if (drm_arst) begin
            rsp_q_reg   <= '0;
            last_reg    <= '0;
            force1_reg  <= 1'b1;
            force2_reg  <= 1'b0;
            pending_reg <= 1'b0;
        end else begin
            rsp_q_reg   <= rsp_word;
            force1_reg  <= load;
            force2_reg  <= force1_reg;
            pending_reg <= want && !push;
            if (push) last_reg <= rsp_q_reg;
        end
    end

    drm_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .W     (32)
    ) u_rsp_fifo (
        .clk      (drm_aclk),
        .srst     (drm_arst),
        .wr_en    (push),
        .wr_data  (rsp_q_reg),
        .rd_en    (pop),
        .rd_data  (uip_to_drm_tdata),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .free_cnt (free_cnt)
    );

    assign uip_to_drm_tvalid = !fifo_empty;

endmodule

// File: tb/tb_drm_activator_axi4st_hub.sv
// Directed bench for the activator hub: command routing, response latency,
// bad-channel handling, back-pressure coalescing and mid-operation reset.
module tb_drm_activator_axi4st_hub;
    localparam int NUM_CH = 4;

    logic                drm_aclk = 1'b0;
    logic                drm_arst;
    logic [31:0]         drm_to_uip_tdata;
    logic                drm_to_uip_tvalid;
    logic                drm_to_uip_tready;
    logic [31:0]         uip_to_drm_tdata;
    logic                uip_to_drm_tvalid;
    logic                uip_to_drm_tready;
    logic [NUM_CH-1:0]   act_cs, act_cyc, act_we, act_dat;
    logic [2*NUM_CH-1:0] act_adr;
    logic [NUM_CH-1:0]   act_ack, act_sta, act_intr, act_rdat;
    logic                err_bad_ch;
    logic [7:0]          bad_ch_count;

    int checks_cnt = 0;
    int fail_cnt   = 0;
    logic [31:0] beat_q[$];

    always #5 drm_aclk = ~drm_aclk;

    drm_activator_axi4st_hub #(.NUM_CH(NUM_CH), .RSP_DEPTH(8)) dut (
        .drm_aclk          (drm_aclk),
        .drm_arst          (drm_arst),
        .drm_to_uip_tdata  (drm_to_uip_tdata),
        .drm_to_uip_tvalid (drm_to_uip_tvalid),
        .drm_to_uip_tready (drm_to_uip_tready),
        .uip_to_drm_tdata  (uip_to_drm_tdata),
        .uip_to_drm_tvalid (uip_to_drm_tvalid),
        .uip_to_drm_tready (uip_to_drm_tready),
        .act_cs            (act_cs),
        .act_cyc           (act_cyc),
        .act_we            (act_we),
        .act_dat           (act_dat),
        .act_adr           (act_adr),
        .act_ack           (act_ack),
        .act_sta           (act_sta),
        .act_intr          (act_intr),
        .act_rdat          (act_rdat),
        .err_bad_ch        (err_bad_ch),
        .bad_ch_count      (bad_ch_count)
    );

    // Handshakes are recorded mid-cycle; inputs only change 1 time unit after posedge.
    always @(negedge drm_aclk) begin
        if (!drm_arst && uip_to_drm_tvalid && uip_to_drm_tready) begin
            beat_q.push_back(uip_to_drm_tdata);
            $display("beat %0d data=0x%08h", beat_q.size(), uip_to_drm_tdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge drm_aclk);
            #1;
        end
    endtask

    function automatic logic [31:0] last_beat();
        return (beat_q.size() > 0) ? beat_q[beat_q.size()-1] : 32'hDEAD_BEEF;
    endfunction

    task automatic stall_run(input string tag, input int toggles, input int exp_cnt,
                             input logic [31:0] exp_last);
        int base;
        uip_to_drm_tready = 1'b0;
        tick(1);
        check({tag, "_tready_open"}, 32'(drm_to_uip_tready), 32'd1);
        for (int i = 0; i < toggles; i++) begin
            act_intr[2] = ~act_intr[2];
            tick(1);
        end
        tick(3);
        check({tag, "_tready_closed"}, 32'(drm_to_uip_tready), 32'd0);
        check({tag, "_tvalid_held"}, 32'(uip_to_drm_tvalid), 32'd1);
        check({tag, "_head"}, uip_to_drm_tdata, 32'h0000_0108);
        tick(1);
        check({tag, "_head_stable"}, uip_to_drm_tdata, 32'h0000_0108);
        base = beat_q.size();
        uip_to_drm_tready = 1'b1;
        tick(15);
        check({tag, "_drain_cnt"}, 32'(beat_q.size() - base), 32'(exp_cnt));
        check({tag, "_final"}, last_beat(), exp_last);
    endtask

    initial begin
        int base;
        drm_arst          = 1'b1;
        drm_to_uip_tdata  = '0;
        drm_to_uip_tvalid = 1'b0;
        uip_to_drm_tready = 1'b1;
        act_ack = '0; act_sta = '0; act_intr = '0; act_rdat = '0;

        tick(3);
        check("rst_tvalid", 32'(uip_to_drm_tvalid), 32'd0);
        check("rst_tready", 32'(drm_to_uip_tready), 32'd0);
        check("rst_cs", 32'(act_cs), 32'd0);
        check("rst_err", 32'(err_bad_ch), 32'd0);
        check("rst_cnt", 32'(bad_ch_count), 32'd0);

        drm_arst = 1'b0;
        tick(6);
        check("boot_cnt", 32'(beat_q.size()), 32'd1);
        check("boot_beat", last_beat(), 32'h0000_0000);

        // Command to channel 1 with cs/cyc; slave acks combinationally.
        drm_to_uip_tdata  = 32'h0000_0130;
        drm_to_uip_tvalid = 1'b1;
        check("lat_tready", 32'(drm_to_uip_tready), 32'd1);
        tick(1);
        drm_to_uip_tvalid = 1'b0;
        act_ack[1] = 1'b1;
        check("lat_cs", 32'(act_cs), 32'h2);
        check("lat_cyc", 32'(act_cyc), 32'h2);
        tick(1);
        check("lat_t2_tvalid", 32'(uip_to_drm_tvalid), 32'd0);
        tick(1);
        check("lat_t3_tvalid", 32'(uip_to_drm_tvalid), 32'd1);
        check("lat_t3_tdata", uip_to_drm_tdata, 32'h0000_0108);
        tick(3);
        check("lat_cnt", 32'(beat_q.size()), 32'd2);

        // Channel 5 does not exist.
        base = beat_q.size();
        drm_to_uip_tdata  = 32'h0000_0530;
        drm_to_uip_tvalid = 1'b1;
        tick(1);
        drm_to_uip_tvalid = 1'b0;
        check("bad_cs", 32'(act_cs), 32'h2);
        check("bad_err", 32'(err_bad_ch), 32'd1);
        check("bad_count", 32'(bad_ch_count), 32'd1);
        tick(5);
        check("bad_no_beat", 32'(beat_q.size() - base), 32'd0);

        act_intr[2] = 1'b1;
        tick(5);
        check("intr_set_beat", last_beat(), 32'h0004_010C);

        stall_run("stall12", 12, 9, 32'h0004_010C);
        stall_run("stall9", 9, 9, 32'h0000_0108);

        // Command to ch0 and an interrupt rise together.
        base = beat_q.size();
        drm_to_uip_tdata  = 32'h0000_003B;
        drm_to_uip_tvalid = 1'b1;
        act_intr[3] = 1'b1;
        tick(1);
        drm_to_uip_tvalid = 1'b0;
        check("same_cs", 32'(act_cs), 32'h1);
        check("same_we", 32'(act_we), 32'h1);
        check("same_dat", 32'(act_dat), 32'h1);
        check("same_adr", 32'(act_adr), 32'h02);
        tick(6);
        check("same_cnt", 32'(beat_q.size() - base), 32'd1);
        check("same_beat", last_beat(), 32'h0008_0004);

        // Reset with three beats queued.
        uip_to_drm_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            act_intr[3] = ~act_intr[3];
            tick(1);
        end
        tick(3);
        check("pre_rst_tvalid", 32'(uip_to_drm_tvalid), 32'd1);
        drm_arst = 1'b1;
        act_intr = '0;
        tick(1);
        check("mid_rst_tvalid", 32'(uip_to_drm_tvalid), 32'd0);
        check("mid_rst_cs", 32'(act_cs), 32'd0);
        check("mid_rst_we", 32'(act_we), 32'd0);
        check("mid_rst_adr", 32'(act_adr), 32'd0);
        check("mid_rst_err", 32'(err_bad_ch), 32'd0);
        check("mid_rst_cnt", 32'(bad_ch_count), 32'd0);
        check("mid_rst_tready", 32'(drm_to_uip_tready), 32'd0);
        drm_arst = 1'b0;
        uip_to_drm_tready = 1'b1;
        base = beat_q.size();
        tick(8);
        check("post_rst_cnt", 32'(beat_q.size() - base), 32'd1);
        check("post_rst_beat", last_beat(), 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
